// File: rtl/req_issuer.sv
// Request issuer: pulses req, waits up to TIMEOUT cycles for ack, retries up to
// MAX_RETRY times, then reports done (with ack latency) or a sticky error.
module req_issuer #(
  parameter int unsigned TIMEOUT   = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  output logic       req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       late,
  output logic [7:0] lat,
  output logic [3:0] retries
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] w_c;
  logic [7:0] lat_nxt;
  logic       late_nxt;
  logic [3:0] retries_nxt;

  // Next-state and datapath decode; w_c is the wait index seen at this edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lat_nxt     = lat;
    late_nxt    = late;
    retries_nxt = retries;
    w_c         = cnt + 8'd1;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_REQ;
          cnt_nxt     = 8'd0;
          retries_nxt = 4'd0;
        end
      end
      S_REQ: begin
        state_nxt = S_WAIT;
        cnt_nxt   = 8'd0;
      end
      S_WAIT: begin
        if (ack) begin
          state_nxt = S_DONE;
          lat_nxt   = w_c;
          late_nxt  = (w_c > 8'd1);
        end else if (w_c == 8'(TIMEOUT)) begin
          cnt_nxt = 8'd0;
          if (retries < 4'(MAX_RETRY)) begin
            retries_nxt = retries + 4'd1;
            state_nxt   = S_REQ;
          end else begin
            state_nxt = S_ERR;
          end
        end else begin
          cnt_nxt = w_c;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      S_ERR: begin
        if (start) begin
          state_nxt   = S_REQ;
          cnt_nxt     = 8'd0;
          retries_nxt = 4'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      req     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      late    <= 1'b0;
      lat     <= 8'd0;
      retries <= 4'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      req     <= (state_nxt == S_REQ);
      busy    <= (state_nxt == S_REQ) || (state_nxt == S_WAIT);
      done    <= (state_nxt == S_DONE);
      err     <= (state_nxt == S_ERR);
      late    <= late_nxt;
      lat     <= lat_nxt;
      retries <= retries_nxt;
    end
  end

endmodule

// File: tb/tb_req_issuer.sv
// Bench for req_issuer: directed and randomized transactions checked each cycle
// against a timeline model derived from attempt period, ack delay and retry budget.
module tb_req_issuer;

  localparam int T = 4;
  localparam int M = 2;
  localparam int P = T + 1;

  logic       clk = 1'b0;
  logic       rst, start, ack;
  logic       req, busy, done, err, late;
  logic [7:0] lat;
  logic [3:0] retries;

  int checks   = 0;
  int failures = 0;
  int exp_lat  = 0;
  int exp_late = 0;
  int exp_ret  = 0;
  int in_err   = 0;
  int ack_hi   = 0;
  logic prev_req = 1'b0;

  req_issuer #(.TIMEOUT(T), .MAX_RETRY(M)) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .req(req), .busy(busy), .done(done), .err(err),
    .late(late), .lat(lat), .retries(retries)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input int e_req, input int e_busy, input int e_done,
                               input int e_err, input int e_ret);
    check("req", int'(req), e_req);
    check("busy", int'(busy), e_busy);
    check("done", int'(done), e_done);
    check("err", int'(err), e_err);
    check("retries", int'(retries), e_ret);
    check("lat", int'(lat), exp_lat);
    check("late", int'(late), exp_late);
    check("req_twice", int'(req && prev_req), 0);
    check("done_busy", int'(done && busy), 0);
    prev_req = req;
  endtask

  function automatic logic rnd_ack();
    return (ack_hi != 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // kf: attempt index that gets acked (kf > M means never acked); d: ack wait index.
  task automatic run_txn(input int kf, input int d);
    int  last_k, end_e, e_ret;
    bit  is_err;
    is_err = (kf > M);
    last_k = is_err ? M : kf;
    end_e  = is_err ? (M + 1) * P : kf * P + 1 + d;
    for (int e = 0; e <= end_e + 1; e++) begin
      if (e == 0) start = 1'b1;
      else if (is_err && e == end_e + 1) start = 1'b0;
      else start = 1'($urandom_range(0, 1));
      if (e == 0 || e > end_e || ((e - 1) % P) == 0) ack = rnd_ack();
      else ack = (!is_err && ((e - 1) / P) == kf && ((e - 1) % P) == d);
      tick;
      if (e == end_e && !is_err) begin
        exp_lat  = d;
        exp_late = (d > 1) ? 1 : 0;
      end
      e_ret = ((e / P) < last_k) ? (e / P) : last_k;
      check_outputs((e % P == 0 && e < end_e) ? 1 : 0, (e < end_e) ? 1 : 0,
                    (!is_err && e == end_e) ? 1 : 0, (is_err && e >= end_e) ? 1 : 0, e_ret);
    end
    start   = 1'b0;
    exp_ret = last_k;
    in_err  = is_err ? 1 : 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      ack   = rnd_ack();
      tick;
      check_outputs(0, 0, 0, in_err, exp_ret);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; ack = 1'b1;
    tick; tick;
    check_outputs(0, 0, 0, 0, 0);
    rst = 1'b0; start = 1'b0; ack = 1'b0;
    idle(2);

    // Compliant, late, and exhausted-retry transactions.
    run_txn(0, 1);
    idle(1);
    run_txn(0, 3);
    idle(2);
    run_txn(M + 1, 0);
    idle(3);
    run_txn(0, 1);
    idle(1);

    // Ack stuck high everywhere.
    ack_hi = 1;
    idle(3);
    run_txn(0, 1);
    idle(2);
    run_txn(0, 1);
    idle(2);
    ack_hi = 0;

    // Reset in WAIT just before w=2 with ack present.
    start = 1'b1; ack = 1'b0; tick;
    start = 1'b0; tick;
    tick;
    rst = 1'b1; ack = 1'b1; tick;
    exp_lat = 0; exp_late = 0; exp_ret = 0; in_err = 0;
    check_outputs(0, 0, 0, 0, 0);
    rst = 1'b0;
    run_txn(0, 1);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      run_txn(int'($urandom_range(0, M + 1)), int'($urandom_range(1, T)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_issuer.md
REQ_ISSUER -- requirements
Module: req_issuer

Interface
REQ-001 Parameter TIMEOUT, default 4: maximum wait cycles for ack after each req pulse; legal range 1..255.
REQ-002 Parameter MAX_RETRY, default 2: re-issues allowed after a timeout before declaring error; legal range 0..15.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  transaction request from the local controller; sampled on rising clk.
REQ-006 ack  input  1  acknowledge from the downstream responder; sampled on rising clk.
REQ-007 req  output  1  request to the responder; registered.
REQ-008 busy  output  1  high while a transaction is in progress (states REQ and WAIT).
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 err  output  1  sticky error after retries are exhausted.
REQ-011 late  output  1  registered with done; high when ack arrived later than the first cycle after req.
REQ-012 lat  output  8  ack latency in cycles of the last completed attempt; 1 = ack on the edge immediately after req.
REQ-013 retries  output  4  re-issues used by the current or last transaction.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, DONE, ERR, with all outputs decoded from registered state or registers (no combinational path from inputs to outputs).
REQ-015 IDLE: req=0, busy=0; start=1 at an edge -> REQ; retries and the wait counter clear on that edge.
REQ-016 REQ: req=1 for exactly one cycle, busy=1; -> WAIT unconditionally; ack sampled in REQ SHALL be ignored.
REQ-017 WAIT: req=0, busy=1; wait counter w increments at each edge, starting at 1 on the first WAIT edge.
REQ-018 WAIT with ack=1 at edge w (w<=TIMEOUT): -> DONE; lat<=w; late<=(w>1).
REQ-019 WAIT reaching w=TIMEOUT with ack=0: if retries<MAX_RETRY, retries<=retries+1 and -> REQ; otherwise -> ERR.
REQ-020 If ack=1 on the same edge the timeout expires, the ack SHALL win (-> DONE).
REQ-021 DONE: done=1 for one cycle; -> IDLE; start in DONE SHALL be ignored.
REQ-022 ERR: err=1, req=0, busy=0; err holds until start=1 (-> REQ, err cleared, retries cleared) or rst.
REQ-023 start while busy SHALL be ignored (no queuing).
REQ-024 ack in IDLE, DONE or ERR SHALL be ignored and SHALL NOT change lat or late.
REQ-025 The wait counter SHALL be 8 bits; retries SHALL saturate at MAX_RETRY and never wrap.
REQ-026 A compliant responder (ack on the edge after req) SHALL yield exactly: start edge t, req high t..t+1, done high t+2..t+3, lat=1, late=0.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and req=0, busy=0, done=0, err=0, late=0, lat=0, retries=0, overriding all other inputs.
REQ-028 rst asserted mid-transaction (REQ or WAIT) SHALL abort with no done or err pulse; a start on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-029 Compliant ack: start at t, ack=1 only at the edge after req -> one req pulse, done one cycle later, lat=1, late=0, retries=0.
REQ-030 Late ack at w=3 with TIMEOUT=4 -> done, lat=3, late=1, retries=0, a single req pulse.
REQ-031 No ack, MAX_RETRY=2, TIMEOUT=4 -> three req pulses spaced 5 cycles apart, then err=1 sticky with retries=2; a later start clears err and re-issues req.
REQ-032 ack held constantly high (including IDLE and REQ) -> lat=1 on every transaction, no spurious done, state stays IDLE with no start.
REQ-033 rst asserted in WAIT at w=2, then ack=1 -> all outputs zero, no done; the next start completes normally.
REQ-034 Concurrent checkers: req |=> ack holds when late=0; done never coincides with busy; req never high for 2 consecutive cycles.
